card_dealer: RTL
================

Name: card_dealer

Overview:
Parametrised successor to the fixed 9-card table dealer. It deals NUM_CARDS unique, valid cards into a packed slot array using a 16-bit LFSR with rejection sampling. It supports staged dealing: a fresh deal clears all slots, and later append deals add hole, flop, turn and river cards without disturbing cards already dealt. It sits between the game-control FSM and the hand evaluator/display.

Parameters:
NUM_CARDS, 9, number of card slots; legal range 1..52
CNT_W, 6, width of count ports; must satisfy 2^CNT_W > NUM_CARDS

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request a deal; sampled only in IDLE
clear  input  1  sampled with start; 1 = fresh deal, 0 = append
num_req  input  CNT_W  number of cards to add on this request
busy  output  1  high while a deal is in progress
done  output  1  one-cycle pulse when the request completes
full  output  1  high when dealt_cnt == NUM_CARDS
dealt_cnt  output  CNT_W  number of slots currently filled
cards  output  6*NUM_CARDS  slot i at [6*(NUM_CARDS-i)-1 -: 6]; slot 0 at MSB
reject_cnt  output  16  rejected candidates (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-low): cards=0, dealt_cnt=0, busy=0, done=0, reject_cnt=0, LFSR=16'h0001, seed counter=16'h0001, FSM=IDLE.
- Card encoding is SSRRRR.
  - Suit: 11 = diamonds, 10 = spades, 01 = hearts, 00 = clubs.
  - Rank: 2..14, where 14 = Ace. A rank of 0, 1 or 15 is invalid.
- Seed counter: free-running; counts 1..FFFF, then wraps to 1. It is never 0.
- LFSR:
  - 16 bits, shifts left, feedback = d[15]^d[14]^d[12]^d[3], random bit = d[0].
  - Advances every cycle while in GATHER.
  - On an accepted fresh start, loads the current seed counter value.
  - On an append start, continues from its current state.
- FSM states: IDLE, GATHER, CHECK, FINISH.
- IDLE:
  - Accept when start=1. target = min(dealt_cnt + num_req, NUM_CARDS).
  - If clear=1: zero all slots and set dealt_cnt=0 before computing target (target = min(num_req, NUM_CARDS)).
  - If target == dealt_cnt after the clear step: go to FINISH.
  - Otherwise: go to GATHER with busy=1.
- GATHER: 6 cycles; each cycle shifts the random bit into the candidate LSB. Then go to CHECK.
- CHECK: 1 cycle.
  - Reject if the rank is invalid, or if the candidate equals any slot j < dealt_cnt (parallel compare).
  - On reject: increment reject_cnt (saturating) and return to GATHER.
  - On accept: write slot[dealt_cnt] and increment dealt_cnt. If the new dealt_cnt == target, go to FINISH; otherwise go to GATHER.
- FINISH: 1 cycle. done=1, busy=0; return to IDLE.
- Latency: minimum 7n+1 cycles from start to the done pulse for n cards; each reject adds 7 cycles.
- Handshakes and boundaries:
  - start while busy is ignored.
  - An append with full=1 produces a done pulse after 1 cycle, with no change to cards.
  - Overflow requests are truncated to the remaining free slots.
  - Slots at index >= dealt_cnt always read 0.
  - Asserting rst_n mid-deal aborts immediately to the reset state; no done pulse.
  - The seed counter advances in every state.

Optional Feature:
Macro DEALER_STATS_EN.
- Defined: reject_cnt counts all rejects since the last fresh start or reset, saturating at 16'hFFFF. A fresh start clears it.
- Undefined: reject_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Reset: hold rst_n=0, then release -> cards=0, dealt_cnt=0, busy=0, full=0, done never pulses.
- Fresh deal (NUM_CARDS=9): start with clear=1, num_req=9 -> single done pulse within 2000 cycles; 9 distinct slots; every rank in 2..14; dealt_cnt=9; full=1; done-to-start latency ≥ 64 cycles.
- Staged append:
  - Fresh deal with num_req=4 -> dealt_cnt=4.
  - Append num_req=3 -> dealt_cnt=7; slots 0-3 bit-identical to before.
  - Append num_req=5 -> dealt_cnt=9 (truncated); all slots distinct.
- Zero and full:
  - num_req=0 with clear=0 -> done pulse 1 cycle after start; cards unchanged.
  - Append while full=1 -> same response.
  - start while busy -> ignored; exactly one done pulse.
- Reset mid-deal: assert rst_n=0 20 cycles after start -> all outputs return to reset values at once; no done pulse.
- Full deck (NUM_CARDS=52, DEALER_STATS_EN defined): fresh deal of 52 -> all 52 legal codes present exactly once; reject_cnt > 0; timeout 200000 cycles.

Source files
------------

// File: rtl/card_dealer.sv
// Deals NUM_CARDS unique SSRRRR cards into a packed slot array using a 16-bit LFSR and rejection sampling.
// Optional macro DEALER_STATS_EN builds a saturating reject counter; without it reject_cnt is tied to 0.
module card_dealer #(
    parameter int NUM_CARDS = 9,
    parameter int CNT_W     = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   clear,
    input  logic [CNT_W-1:0]       num_req,
    output logic                   busy,
    output logic                   done,
    output logic                   full,
    output logic [CNT_W-1:0]       dealt_cnt,
    output logic [6*NUM_CARDS-1:0] cards,
    output logic [15:0]            reject_cnt,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GATHER = 2'd1,
        S_CHECK  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [CNT_W:0]   LP_N_EXT = (CNT_W+1)'(NUM_CARDS);
    localparam logic [CNT_W-1:0] LP_N     = CNT_W'(NUM_CARDS);

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_lfsr;
    logic [15:0]      r_seed;
    logic [5:0]       r_cand;
    logic [2:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_target;
    logic [5:0]       r_slot [NUM_CARDS];

    logic [CNT_W:0]   w_base;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W:0]   w_target;
    logic             w_fb;
    logic             w_dup;
    logic             w_rank_ok;
    logic             w_accept;

    // Target is clamped so oversized requests just fill the remaining slots.
    assign w_base    = clear ? '0 : {1'b0, r_cnt};
    assign w_sum     = w_base + {1'b0, num_req};
    assign w_target  = (w_sum > LP_N_EXT) ? LP_N_EXT : w_sum;

    assign w_fb      = r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3];
    assign w_rank_ok = (r_cand[3:0] >= 4'd2) && (r_cand[3:0] <= 4'd14);
    assign w_accept  = w_rank_ok && !w_dup;

    always_comb begin
        w_dup = 1'b0;
        for (int j = 0; j < NUM_CARDS; j++) begin
            if ((CNT_W'(j) < r_cnt) && (r_slot[j] == r_cand)) begin
                w_dup = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (w_target == w_base) ? S_FINISH : S_GATHER;
                end
            end
            S_GATHER: begin
                if (r_bit_cnt == 3'd5) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_accept && ((r_cnt + CNT_W'(1)) == r_target)) begin
                    w_next = S_FINISH;
                end else begin
                    w_next = S_GATHER;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr    <= 16'h0001;
            r_seed    <= 16'h0001;
            r_cand    <= '0;
            r_bit_cnt <= '0;
            r_cnt     <= '0;
            r_target  <= '0;
            for (int i = 0; i < NUM_CARDS; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            // The seed counter skips zero so a fresh LFSR load is never stuck.
            r_seed <= (r_seed == 16'hFFFF) ? 16'h0001 : r_seed + 16'h0001;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_target  <= w_target[CNT_W-1:0];
                        r_bit_cnt <= '0;
                        if (clear) begin
                            r_cnt  <= '0;
                            r_lfsr <= r_seed;
                            for (int i = 0; i < NUM_CARDS; i++) begin
                                r_slot[i] <= '0;
                            end
                        end
                    end
                end
                S_GATHER: begin
                    r_cand    <= {r_cand[4:0], r_lfsr[0]};
                    r_lfsr    <= {r_lfsr[14:0], w_fb};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                S_CHECK: begin
                    r_bit_cnt <= '0;
                    if (w_accept) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        for (int i = 0; i < NUM_CARDS; i++) begin
                            if (CNT_W'(i) == r_cnt) begin
                                r_slot[i] <= r_cand;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DEALER_STATS_EN
    logic [15:0] r_rej;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rej <= '0;
        end else if ((r_state == S_IDLE) && start && clear) begin
            r_rej <= '0;
        end else if ((r_state == S_CHECK) && !w_accept && (r_rej != 16'hFFFF)) begin
            r_rej <= r_rej + 16'h0001;
        end
    end

    assign reject_cnt = r_rej;
`else
    assign reject_cnt = 16'h0000;
`endif

    // Slot 0 occupies the most significant six bits.
    always_comb begin
        cards = '0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            cards[6*(NUM_CARDS-i)-1 -: 6] = r_slot[i];
        end
    end

    assign busy      = (r_state == S_GATHER) || (r_state == S_CHECK);
    assign done      = (r_state == S_FINISH);
    assign full      = (r_cnt == LP_N);
    assign dealt_cnt = r_cnt;
    assign dbg_state = r_state;

endmodule
